// File: rtl/cnn_pkg.sv
// Shared CNN accelerator definitions: bus widths, pixel type and pool-engine states.
package cnn_pkg;

    localparam int MEM_ADDR_SIZE = 20;
    localparam int DATA_SIZE     = 16;

    typedef logic signed [DATA_SIZE-1:0] pixel_t;

    typedef enum logic [2:0] {
        POOL_IDLE,
        POOL_RD0,
        POOL_RD1,
        POOL_RD2,
        POOL_RD3,
        POOL_CAP,
        POOL_WR,
        POOL_DONE
    } pool_state_t;

endpackage

// File: rtl/pool_addr_gen.sv
// Address walker for 2x2 stride-2 pooling: q/r/c counters plus incremental
// source/destination pointers. The only multiply is S*S, taken once at start.
module pool_addr_gen #(
    parameter int AW = 20,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          advance,
    input  logic [AW-1:0] img_addr,
    input  logic [AW-1:0] out_addr,
    input  logic [DW-1:0] img_size,
    input  logic [DW-1:0] maps_count,
    output logic [AW-1:0] pix_addr,
    output logic [AW-1:0] row_stride,
    output logic [AW-1:0] wr_addr,
    output logic          last_pixel,
    output logic          degenerate
);

    logic [AW-1:0] map_base_q, map_base_d;
    logic [AW-1:0] row_base_q, row_base_d;
    logic [AW-1:0] pix_q, pix_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] s_q, s_d;
    logic [AW-1:0] sq_q, sq_d;
    logic [DW-1:0] h_q, h_d;
    logic [DW-1:0] maps_q, maps_d;
    logic [DW-1:0] q_q, q_d;
    logic [DW-1:0] r_q, r_d;
    logic [DW-1:0] c_q, c_d;
    logic [AW-1:0] size_aw;
    logic          q_last, r_last;

    // Casting to the address width first makes S*S wrap with the address space.
    assign size_aw    = AW'(img_size);
    assign degenerate = (img_size < DW'(2)) || (maps_count == '0);

    assign q_last     = (q_q == h_q - DW'(1));
    assign r_last     = (r_q == h_q - DW'(1));
    assign last_pixel = q_last && r_last && (c_q == maps_q - DW'(1));

    assign pix_addr   = pix_q;
    assign row_stride = s_q;
    assign wr_addr    = dst_q;

    // Load job geometry on start; step q, then r, then c after every write.
    always_comb begin
        map_base_d = map_base_q;
        row_base_d = row_base_q;
        pix_d      = pix_q;
        dst_d      = dst_q;
        s_d        = s_q;
        sq_d       = sq_q;
        h_d        = h_q;
        maps_d     = maps_q;
        q_d        = q_q;
        r_d        = r_q;
        c_d        = c_q;
        if (start) begin
            map_base_d = img_addr;
            row_base_d = img_addr;
            pix_d      = img_addr;
            dst_d      = out_addr;
            s_d        = size_aw;
            sq_d       = size_aw * size_aw;
            h_d        = img_size >> 1;
            maps_d     = maps_count;
            q_d        = '0;
            r_d        = '0;
            c_d        = '0;
        end else if (advance) begin
            dst_d = dst_q + AW'(1);
            if (!q_last) begin
                q_d   = q_q + DW'(1);
                pix_d = pix_q + AW'(2);
            end else if (!r_last) begin
                q_d        = '0;
                r_d        = r_q + DW'(1);
                row_base_d = row_base_q + {s_q[AW-2:0], 1'b0};
                pix_d      = row_base_q + {s_q[AW-2:0], 1'b0};
            end else begin
                // Jumping to the next map skips any dropped odd row/column.
                q_d        = '0;
                r_d        = '0;
                c_d        = c_q + DW'(1);
                map_base_d = map_base_q + sq_q;
                row_base_d = map_base_q + sq_q;
                pix_d      = map_base_q + sq_q;
            end
        end
    end

    // Walker state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            map_base_q <= '0;
            row_base_q <= '0;
            pix_q      <= '0;
            dst_q      <= '0;
            s_q        <= '0;
            sq_q       <= '0;
            h_q        <= '0;
            maps_q     <= '0;
            q_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
        end else begin
            map_base_q <= map_base_d;
            row_base_q <= row_base_d;
            pix_q      <= pix_d;
            dst_q      <= dst_d;
            s_q        <= s_d;
            sq_q       <= sq_d;
            h_q        <= h_d;
            maps_q     <= maps_d;
            q_q        <= q_d;
            r_q        <= r_d;
            c_q        <= c_d;
        end
    end

endmodule

// File: rtl/cnn_max_pool.sv
// 2x2 stride-2 signed max-pooling engine: six-cycle-per-pixel FSM with a
// running max; all memory strobes and addresses are decoded from state.
module cnn_max_pool
    import cnn_pkg::pool_state_t, cnn_pkg::POOL_IDLE, cnn_pkg::POOL_RD0,
           cnn_pkg::POOL_RD1, cnn_pkg::POOL_RD2, cnn_pkg::POOL_RD3,
           cnn_pkg::POOL_CAP, cnn_pkg::POOL_WR, cnn_pkg::POOL_DONE;
#(
    parameter int MEM_ADDR_SIZE = cnn_pkg::MEM_ADDR_SIZE,
    parameter int DATA_SIZE     = cnn_pkg::DATA_SIZE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     poolEnable,
    input  logic [MEM_ADDR_SIZE-1:0] imgAddr,
    input  logic [MEM_ADDR_SIZE-1:0] outAddr,
    input  logic [DATA_SIZE-1:0]     imgSize,
    input  logic [DATA_SIZE-1:0]     prevImagesCount,
    output logic                     memRdEn,
    output logic [MEM_ADDR_SIZE-1:0] memRdAddr,
    input  logic [DATA_SIZE-1:0]     memRdData,
    output logic                     memWrEn,
    output logic [MEM_ADDR_SIZE-1:0] memWrAddr,
    output logic [DATA_SIZE-1:0]     memWrData,
    output logic                     busy,
    output logic                     convORpoolDone
);

    pool_state_t                  state_q, state_d;
    logic signed [DATA_SIZE-1:0]  max_q, max_d;
    logic signed [DATA_SIZE-1:0]  rd_pixel;
    logic                         start, advance, last_pixel, degenerate;
    logic [MEM_ADDR_SIZE-1:0]     pix_addr, row_stride, wr_addr;

    assign rd_pixel = memRdData;
    assign start    = (state_q == POOL_IDLE) && poolEnable;
    assign advance  = (state_q == POOL_WR);

    pool_addr_gen #(
        .AW(MEM_ADDR_SIZE),
        .DW(DATA_SIZE)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .advance   (advance),
        .img_addr  (imgAddr),
        .out_addr  (outAddr),
        .img_size  (imgSize),
        .maps_count(prevImagesCount),
        .pix_addr  (pix_addr),
        .row_stride(row_stride),
        .wr_addr   (wr_addr),
        .last_pixel(last_pixel),
        .degenerate(degenerate)
    );

    // Next-state: fixed RD0..WR pixel loop; empty jobs go straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            POOL_IDLE: if (poolEnable) state_d = degenerate ? POOL_DONE : POOL_RD0;
            POOL_RD0:  state_d = POOL_RD1;
            POOL_RD1:  state_d = POOL_RD2;
            POOL_RD2:  state_d = POOL_RD3;
            POOL_RD3:  state_d = POOL_CAP;
            POOL_CAP:  state_d = POOL_WR;
            POOL_WR:   state_d = last_pixel ? POOL_DONE : POOL_RD0;
            POOL_DONE: state_d = POOL_IDLE;
            default:   state_d = POOL_IDLE;
        endcase
    end

    // Running max: read data lags the strobe by one cycle, so RD1 seeds it.
    always_comb begin
        max_d = max_q;
        case (state_q)
            POOL_RD1: max_d = rd_pixel;
            POOL_RD2, POOL_RD3, POOL_CAP: if (rd_pixel > max_q) max_d = rd_pixel;
            default: max_d = max_q;
        endcase
    end

    // State and max registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= POOL_IDLE;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
        end
    end

    // Moore output decode; addresses and data are forced to zero when unused.
    always_comb begin
        memRdEn        = 1'b0;
        memRdAddr      = '0;
        memWrEn        = 1'b0;
        memWrAddr      = '0;
        memWrData      = '0;
        convORpoolDone = 1'b0;
        busy           = (state_q != POOL_IDLE);
        case (state_q)
            POOL_RD0: begin
                memRdEn   = 1'b1;
                memRdAddr = pix_addr;
            end
            POOL_RD1: begin
                memRdEn   = 1'b1;
                memRdAddr = pix_addr + MEM_ADDR_SIZE'(1);
            end
            POOL_RD2: begin
                memRdEn   = 1'b1;
                memRdAddr = pix_addr + row_stride;
            end
            POOL_RD3: begin
                memRdEn   = 1'b1;
                memRdAddr = pix_addr + row_stride + MEM_ADDR_SIZE'(1);
            end
            POOL_WR: begin
                memWrEn   = 1'b1;
                memWrAddr = wr_addr;
                memWrData = max_q;
            end
            POOL_DONE: convORpoolDone = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cnn_max_pool.sv
// Directed bench for cnn_max_pool: table of pooling jobs plus hand-written
// reset, mid-job start and back-to-back start sequences.
module tb_cnn_max_pool;
    import cnn_pkg::*;

    localparam int AW = MEM_ADDR_SIZE;
    localparam int DW = DATA_SIZE;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          poolEnable = 1'b0;
    logic [AW-1:0] imgAddr = '0;
    logic [AW-1:0] outAddr = '0;
    logic [DW-1:0] imgSize = '0;
    logic [DW-1:0] prevImagesCount = '0;
    logic          memRdEn;
    logic [AW-1:0] memRdAddr;
    logic [DW-1:0] memRdData = '0;
    logic          memWrEn;
    logic [AW-1:0] memWrAddr;
    logic [DW-1:0] memWrData;
    logic          busy;
    logic          convORpoolDone;

    cnn_max_pool dut (
        .clk            (clk),
        .reset          (reset),
        .poolEnable     (poolEnable),
        .imgAddr        (imgAddr),
        .outAddr        (outAddr),
        .imgSize        (imgSize),
        .prevImagesCount(prevImagesCount),
        .memRdEn        (memRdEn),
        .memRdAddr      (memRdAddr),
        .memRdData      (memRdData),
        .memWrEn        (memWrEn),
        .memWrAddr      (memWrAddr),
        .memWrData      (memWrData),
        .busy           (busy),
        .convORpoolDone (convORpoolDone)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Feature memory model: one-cycle read latency.
    pixel_t mem [0:1023];
    bit     allowed [0:1023];
    always @(posedge clk) if (memRdEn) memRdData <= mem[memRdAddr[9:0]];

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    wr_t wr_log[$];
    int  done_q[$];
    int  rd_count = 0;
    int  bad_reads = 0;
    wr_t w;

    always @(negedge clk) begin
        if (memWrEn) begin
            w.cyc  = cyc;
            w.addr = int'(memWrAddr);
            w.data = int'($signed(memWrData));
            wr_log.push_back(w);
        end
        if (memRdEn) begin
            rd_count++;
            if (memRdAddr >= AW'(1024) || !allowed[memRdAddr[9:0]]) bad_reads++;
        end
        if (convORpoolDone) done_q.push_back(cyc);
    end

    typedef struct {
        int              s;
        int              c;
        int              src_addr;
        int              dst_addr;
        int              n;
        int              lat;
        logic [24:0][15:0] src;
        logic [3:0][15:0]  exp;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Fill memory and mark exactly the pixels a correct pooling pass may read.
    task automatic load_mem(input vec_t v);
        int h;
        h = v.s / 2;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = '0;
            allowed[i] = 1'b0;
        end
        for (int cc = 0; cc < v.c; cc++)
            for (int rr = 0; rr < 2 * h; rr++)
                for (int col = 0; col < 2 * h; col++)
                    allowed[v.src_addr + cc * v.s * v.s + rr * v.s + col] = 1'b1;
        for (int i = 0; i < v.s * v.s * v.c && i < 25; i++)
            mem[v.src_addr + i] = v.src[i];
    endtask

    task automatic start_job(input vec_t v, output int t0);
        imgAddr         = AW'(v.src_addr);
        outAddr         = AW'(v.dst_addr);
        imgSize         = DW'(v.s);
        prevImagesCount = DW'(v.c);
        poolEnable      = 1'b1;
        t0              = cyc;
        tick();
        poolEnable      = 1'b0;
        imgAddr         = '1;
        outAddr         = '1;
        imgSize         = DW'(3);
        prevImagesCount = DW'(5);
    endtask

    task automatic run_job(input vec_t v, input int vi, input bit glitch);
        int t0, rb, bb, wb, db, nd;
        load_mem(v);
        rb = rd_count;
        bb = bad_reads;
        wb = wr_log.size();
        db = done_q.size();
        start_job(v, t0);
        check($sformatf("v%0d busy_after_start", vi), int'(busy), 1);
        while (done_q.size() == db && cyc < t0 + 400) begin
            poolEnable = glitch && (cyc == t0 + 8);
            tick();
        end
        poolEnable = 1'b0;
        tick();
        tick();
        nd = done_q.size() - db;
        check($sformatf("v%0d done_pulses", vi), nd, 1);
        if (nd > 0) check($sformatf("v%0d done_cycle", vi), done_q[db] - t0, v.lat);
        check($sformatf("v%0d busy_after_done", vi), int'(busy), 0);
        check($sformatf("v%0d write_count", vi), wr_log.size() - wb, v.n);
        check($sformatf("v%0d read_count", vi), rd_count - rb, 4 * v.n);
        check($sformatf("v%0d bad_reads", vi), bad_reads - bb, 0);
        for (int k = 0; k < v.n && wb + k < wr_log.size(); k++) begin
            check($sformatf("v%0d wr%0d addr", vi, k), wr_log[wb + k].addr, v.dst_addr + k);
            check($sformatf("v%0d wr%0d data", vi, k), wr_log[wb + k].data, int'($signed(v.exp[k])));
            check($sformatf("v%0d wr%0d cycle", vi, k), wr_log[wb + k].cyc - t0, 6 + 6 * k);
        end
    endtask

    vec_t vecs[7];
    vec_t bb_v;

    initial begin
        int t0, db, wb;

        // 0: S=4 ascending 1..16
        vecs[0].s = 4; vecs[0].c = 1; vecs[0].src_addr = 40; vecs[0].dst_addr = 200;
        vecs[0].n = 4; vecs[0].lat = 25;
        for (int i = 0; i < 16; i++) vecs[0].src[i] = 16'(i + 1);
        vecs[0].exp[0] = 16'(6);  vecs[0].exp[1] = 16'(8);
        vecs[0].exp[2] = 16'(14); vecs[0].exp[3] = 16'(16);
        // 1: S=4 all negative -16..-1
        vecs[1].s = 4; vecs[1].c = 1; vecs[1].src_addr = 100; vecs[1].dst_addr = 300;
        vecs[1].n = 4; vecs[1].lat = 25;
        for (int i = 0; i < 16; i++) vecs[1].src[i] = 16'(i - 16);
        vecs[1].exp[0] = 16'(-11); vecs[1].exp[1] = 16'(-9);
        vecs[1].exp[2] = 16'(-3);  vecs[1].exp[3] = 16'(-1);
        // 2: S=5, dropped row/column hold large bait values
        vecs[2].s = 5; vecs[2].c = 1; vecs[2].src_addr = 500; vecs[2].dst_addr = 600;
        vecs[2].n = 4; vecs[2].lat = 25;
        for (int i = 0; i < 25; i++)
            vecs[2].src[i] = (i % 5 == 4 || i / 5 == 4) ? 16'(1000) : 16'(i + 1);
        vecs[2].exp[0] = 16'(7);  vecs[2].exp[1] = 16'(9);
        vecs[2].exp[2] = 16'(17); vecs[2].exp[3] = 16'(19);
        // 3: S=2, three maps
        vecs[3].s = 2; vecs[3].c = 3; vecs[3].src_addr = 10; vecs[3].dst_addr = 900;
        vecs[3].n = 3; vecs[3].lat = 19;
        vecs[3].src[0] = 16'(1);  vecs[3].src[1] = 16'(2);  vecs[3].src[2] = 16'(3);  vecs[3].src[3] = 16'(4);
        vecs[3].src[4] = 16'(-5); vecs[3].src[5] = 16'(0);  vecs[3].src[6] = 16'(-7); vecs[3].src[7] = 16'(-8);
        for (int i = 8; i < 12; i++) vecs[3].src[i] = 16'(9);
        vecs[3].exp[0] = 16'(4); vecs[3].exp[1] = 16'(0); vecs[3].exp[2] = 16'(9);
        // 4: S=1 degenerate
        vecs[4].s = 1; vecs[4].c = 1; vecs[4].src_addr = 30; vecs[4].dst_addr = 800;
        vecs[4].n = 0; vecs[4].lat = 1; vecs[4].src[0] = 16'(5);
        // 5: C=0 degenerate
        vecs[5].s = 4; vecs[5].c = 0; vecs[5].src_addr = 40; vecs[5].dst_addr = 800;
        vecs[5].n = 0; vecs[5].lat = 1;
        // 6: S=3, two maps: odd size plus map stride
        vecs[6].s = 3; vecs[6].c = 2; vecs[6].src_addr = 60; vecs[6].dst_addr = 700;
        vecs[6].n = 2; vecs[6].lat = 13;
        for (int i = 0; i < 9; i++) vecs[6].src[i] = 16'(i + 1);
        for (int i = 9; i < 18; i++) vecs[6].src[i] = 16'(8 - i);
        vecs[6].exp[0] = 16'(5); vecs[6].exp[1] = 16'(-1);

        // Reset state
        tick();
        tick();
        check("reset memRdEn", int'(memRdEn), 0);
        check("reset memWrEn", int'(memWrEn), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(convORpoolDone), 0);
        check("reset memRdAddr", int'(memRdAddr), 0);
        check("reset memWrAddr", int'(memWrAddr), 0);
        check("reset memWrData", int'(memWrData), 0);
        reset = 1'b0;
        tick();

        for (int vi = 0; vi < 7; vi++) run_job(vecs[vi], vi, 1'b0);

        // Reset during WR of pixel 1: everything clears, no done pulse follows.
        load_mem(vecs[0]);
        db = done_q.size();
        start_job(vecs[0], t0);
        while (cyc < t0 + 12) tick();
        check("midreset wr_active", int'(memWrEn), 1);
        check("midreset wr_addr", int'(memWrAddr), 201);
        check("midreset wr_data", int'($signed(memWrData)), 8);
        reset = 1'b1;
        tick();
        check("midreset memRdEn", int'(memRdEn), 0);
        check("midreset memWrEn", int'(memWrEn), 0);
        check("midreset busy", int'(busy), 0);
        check("midreset done", int'(convORpoolDone), 0);
        check("midreset memRdAddr", int'(memRdAddr), 0);
        check("midreset memWrAddr", int'(memWrAddr), 0);
        check("midreset memWrData", int'(memWrData), 0);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("midreset no_done", done_q.size() - db, 0);
        check("midreset idle", int'(busy), 0);

        // Fresh job after reset, with a stray poolEnable pulse mid-job.
        run_job(vecs[0], 10, 1'b1);

        // Back-to-back: poolEnable held through DONE restarts from IDLE.
        bb_v.s = 2; bb_v.c = 1; bb_v.src_addr = 10; bb_v.dst_addr = 950;
        bb_v.n = 1; bb_v.lat = 7;
        bb_v.src[0] = 16'(1); bb_v.src[1] = 16'(2); bb_v.src[2] = 16'(3); bb_v.src[3] = 16'(4);
        bb_v.exp[0] = 16'(4);
        load_mem(bb_v);
        db = done_q.size();
        wb = wr_log.size();
        imgAddr         = AW'(bb_v.src_addr);
        outAddr         = AW'(bb_v.dst_addr);
        imgSize         = DW'(bb_v.s);
        prevImagesCount = DW'(bb_v.c);
        poolEnable      = 1'b1;
        t0              = cyc;
        while (done_q.size() - db < 2 && cyc < t0 + 100) tick();
        poolEnable = 1'b0;
        tick();
        tick();
        check("b2b done_pulses", done_q.size() - db, 2);
        if (done_q.size() - db >= 2) begin
            check("b2b done0_cycle", done_q[db] - t0, 7);
            check("b2b done1_cycle", done_q[db + 1] - t0, 15);
        end
        check("b2b write_count", wr_log.size() - wb, 2);
        if (wr_log.size() - wb >= 2) begin
            check("b2b wr0 cycle", wr_log[wb].cyc - t0, 6);
            check("b2b wr1 cycle", wr_log[wb + 1].cyc - t0, 14);
            check("b2b wr0 addr", wr_log[wb].addr, 950);
            check("b2b wr1 addr", wr_log[wb + 1].addr, 950);
            check("b2b wr0 data", wr_log[wb].data, 4);
            check("b2b wr1 data", wr_log[wb + 1].data, 4);
        end
        check("b2b idle", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
